rr_coin_mux: RTL and testbench

- Parametrised N-channel, W-bit arbitrating multiplexer with a registered output stage.
- Collects values from several requesters, e.g. coin slots reporting coin value, and forwards one value per transfer to the credit accumulator.
- Succeeds the 2:1 select primitive. Adds a channel count, a data width, fixed-priority or round-robin selection, a req/gnt input handshake and a valid/ready output handshake.

---
 rtl/rr_coin_mux.sv | 138 +++++++++++++
 tb/tb_rr_coin_mux.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rr_coin_mux.sv
// N-channel arbitrating coin mux: fixed-priority or round-robin grant with a registered valid/ready output stage.
// Optional build macro RR_COIN_MUX_FORCE_EN adds force_en/force_sel to pin selection to one channel.
module rr_coin_mux #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 8,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef RR_COIN_MUX_FORCE_EN
  input  logic                      force_en,
  input  logic [SELW-1:0]           force_sel,
`endif
  output logic [CHANNELS-1:0]       gnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q;
  logic              outValid_q;
  logic [WIDTH-1:0]  outData_q;
  logic [SELW-1:0]   outChan_q;
  logic [SELW-1:0]   last_q;

  logic [SELW-1:0]   sel;
  logic              found;
  logic              forced;
  logic              load;
  logic              grant;
  logic [WIDTH-1:0]  selData_d;
  logic [SELW-1:0]   hiSel;
  logic              hiFound;
  logic [SELW-1:0]   loSel;
  logic              loFound;

  // Round-robin splits requests into those above the last grant and the rest;
  // the upper group wins, which gives the wrap-around search order.
  always_comb begin
    sel     = '0;
    found   = 1'b0;
    forced  = 1'b0;
    hiSel   = '0;
    hiFound = 1'b0;
    loSel   = '0;
    loFound = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i]) begin
        loSel   = SELW'(i);
        loFound = 1'b1;
        if (i > int'(last_q)) begin
          hiSel   = SELW'(i);
          hiFound = 1'b1;
        end
      end
    end
    if (!mode) begin
      sel   = loSel;
      found = loFound;
    end else begin
      sel   = hiFound ? hiSel : loSel;
      found = hiFound | loFound;
    end
`ifdef RR_COIN_MUX_FORCE_EN
    if (force_en) begin
      forced = 1'b1;
      sel    = force_sel;
      found  = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (i == int'(force_sel) && req[i]) begin
          found = 1'b1;
        end
      end
    end
`endif
  end

  assign load      = ~outValid_q | out_ready;
  assign grant     = rst_n & load & found;
  assign selData_d = in_data[int'(sel)*WIDTH +: WIDTH];

  always_comb begin
    gnt = '0;
    if (grant) begin
      gnt[sel] = 1'b1;
    end
  end

  // A grant always loads the output register, so FULL with out_ready and a
  // pending request streams one item per clock without an idle gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outChan_q  <= '0;
      last_q     <= SELW'(CHANNELS - 1);
    end else begin
      if (grant && !forced) begin
        last_q <= sel;
      end
      case (state_q)
        EMPTY: begin
          if (grant) begin
            outData_q  <= selData_d;
            outChan_q  <= sel;
            outValid_q <= 1'b1;
            state_q    <= FULL;
          end
        end
        FULL: begin
          if (grant) begin
            outData_q <= selData_d;
            outChan_q <= sel;
          end else if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= EMPTY;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          state_q    <= EMPTY;
        end
      endcase
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_chan  = outChan_q;

endmodule

// File: tb/tb_rr_coin_mux.sv
// Table-driven bench for rr_coin_mux (CHANNELS=4, WIDTH=8, default build without the force feature).
// Each vector drives inputs, checks the combinational grant, then checks the registered outputs after the edge.
module tb_rr_coin_mux;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [3:0]  req;
  logic [31:0] in_data;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;

  int checkCount;
  int passCount;

  rr_coin_mux #(.CHANNELS(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstN;
    logic        mode;
    logic [3:0]  req;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  expGnt;
    logic        expValid;
    logic        chkData;
    logic [7:0]  expData;
    logic [1:0]  expChan;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic rstN, logic md, logic [3:0] rq, logic [31:0] dat, logic rdy,
                                 logic [3:0] eg, logic ev, logic cd, logic [7:0] ed, logic [1:0] ec);
    vec_t v;
    v.rstN = rstN; v.mode = md; v.req = rq; v.data = dat; v.ready = rdy;
    v.expGnt = eg; v.expValid = ev; v.chkData = cd; v.expData = ed; v.expChan = ec;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rst_n     = v.rstN;
    mode      = v.mode;
    req       = v.req;
    in_data   = v.data;
    out_ready = v.ready;
    #1;
    checkOutput($sformatf("gnt[v%0d]", idx), {28'd0, gnt}, {28'd0, v.expGnt});
    @(posedge clk);
    #1;
    checkOutput($sformatf("out_valid[v%0d]", idx), {31'd0, out_valid}, {31'd0, v.expValid});
    if (v.chkData) begin
      checkOutput($sformatf("out_data[v%0d]", idx), {24'd0, out_data}, {24'd0, v.expData});
      checkOutput($sformatf("out_chan[v%0d]", idx), {30'd0, out_chan}, {30'd0, v.expChan});
    end
  endtask

  initial begin
    int waitCycles;
    checkCount = 0;
    passCount  = 0;
    rst_n = 1'b0; mode = 1'b0; req = '0; in_data = '0; out_ready = 1'b0;

    // Reset, then idle
    for (int i = 0; i < 2; i++) vecs.push_back(mkVec(0, 0, 4'b0000, 32'h0, 0, 4'b0000, 0, 1, 8'h00, 2'd0));
    for (int i = 0; i < 5; i++) vecs.push_back(mkVec(1, 0, 4'b0000, 32'h0, 0, 4'b0000, 0, 1, 8'h00, 2'd0));
    // Fixed priority: ch1 before ch3
    vecs.push_back(mkVec(1, 0, 4'b1010, 32'h19000500, 1, 4'b0010, 1, 1, 8'h05, 2'd1));
    vecs.push_back(mkVec(1, 0, 4'b1000, 32'h19000500, 1, 4'b1000, 1, 1, 8'h19, 2'd3));
    vecs.push_back(mkVec(1, 0, 4'b0000, 32'h19000500, 1, 4'b0000, 0, 0, 8'h00, 2'd0));
    // Round-robin, all requesting, back-to-back
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        vecs.push_back(mkVec(1, 1, 4'b1111, 32'h04030201, 1, 4'(1 << c), 1, 1, 8'(c + 1), 2'(c)));
      end
    end
    vecs.push_back(mkVec(1, 1, 4'b0000, 32'h04030201, 1, 4'b0000, 0, 0, 8'h00, 2'd0));
    // Backpressure holds 0A, then streams ch2
    vecs.push_back(mkVec(1, 0, 4'b0001, 32'h000B000A, 1, 4'b0001, 1, 1, 8'h0A, 2'd0));
    for (int i = 0; i < 3; i++) vecs.push_back(mkVec(1, 0, 4'b0100, 32'h000B000A, 0, 4'b0000, 1, 1, 8'h0A, 2'd0));
    vecs.push_back(mkVec(1, 0, 4'b0100, 32'h000B000A, 1, 4'b0100, 1, 1, 8'h0B, 2'd2));
    // Reset while FULL restores the pointer to ch3
    vecs.push_back(mkVec(0, 1, 4'b0100, 32'h000B000A, 1, 4'b0000, 0, 1, 8'h00, 2'd0));
    vecs.push_back(mkVec(1, 1, 4'b1001, 32'h33000011, 1, 4'b0001, 1, 1, 8'h11, 2'd0));
    vecs.push_back(mkVec(1, 1, 4'b1000, 32'h33000011, 1, 4'b1000, 1, 1, 8'h33, 2'd3));
    // Single requester repeatedly granted
    for (int i = 0; i < 3; i++) vecs.push_back(mkVec(1, 1, 4'b0010, 32'h00002200, 1, 4'b0010, 1, 1, 8'h22, 2'd1));
    // Pointer tracks fixed-priority grants, then round-robin continues from it
    vecs.push_back(mkVec(1, 0, 4'b0011, 32'h00004433, 1, 4'b0001, 1, 1, 8'h33, 2'd0));
    vecs.push_back(mkVec(1, 1, 4'b0011, 32'h00004433, 1, 4'b0010, 1, 1, 8'h44, 2'd1));
    vecs.push_back(mkVec(1, 1, 4'b0011, 32'h00004433, 1, 4'b0001, 1, 1, 8'h33, 2'd0));
    vecs.push_back(mkVec(1, 1, 4'b0000, 32'h00004433, 1, 4'b0000, 0, 0, 8'h00, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Grant from EMPTY with out_ready low, then the held item blocks further grants
    req = 4'b0100; mode = 1'b1; in_data = 32'h00770000; out_ready = 1'b0;
    waitCycles = 0;
    #1;
    while (gnt == 4'b0000 && waitCycles < 5) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("seq gnt", {28'd0, gnt}, 32'h4);
    @(posedge clk);
    #1;
    checkOutput("seq valid", {31'd0, out_valid}, 32'h1);
    checkOutput("seq data", {24'd0, out_data}, 32'h77);
    checkOutput("seq chan", {30'd0, out_chan}, 32'h2);
    for (int i = 0; i < 2; i++) begin
      checkOutput("seq stall gnt", {28'd0, gnt}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("seq stall valid", {31'd0, out_valid}, 32'h1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
